// File: rtl/tcpc_pkg.sv
// Shared TCPC transmit definitions: TRANSMIT type codes, arbiter state
// encodings and type classification helpers.
package tcpc_pkg;

  localparam logic [2:0] TX_SOP         = 3'd0;
  localparam logic [2:0] TX_SOP1        = 3'd1;
  localparam logic [2:0] TX_SOP2        = 3'd2;
  localparam logic [2:0] TX_HARD_RESET  = 3'd5;
  localparam logic [2:0] TX_CABLE_RESET = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WAIT_BUS = 4'b0010,
    ST_REQUEST  = 4'b0100,
    ST_REPORT   = 4'b1000
  } tx_state_e;

  function automatic logic is_reset_type(input logic [2:0] t);
    return (t == TX_HARD_RESET) || (t == TX_CABLE_RESET);
  endfunction

  function automatic logic is_msg_type(input logic [2:0] t);
    return (t == TX_SOP) || (t == TX_SOP1) || (t == TX_SOP2);
  endfunction

endpackage

// File: rtl/tcpc_tx_timer.sv
// Loadable saturating down-counter; expired_o is high while the count is 0.
module tcpc_tx_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/tcpc_tx_arbiter.sv
// Arbitrates the PHY transmit path between SOP* messages and Hard/Cable
// Resets; every accepted request ends in exactly one alert pulse.
module tcpc_tx_arbiter
  import tcpc_pkg::*;
#(
  parameter int unsigned TIMER_W = 32,
  parameter int unsigned RETRY_W = 2
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               transmit_wr,
  input  logic [2:0]         transmit_type,
  input  logic [RETRY_W-1:0] transmit_retry,
  input  logic [TIMER_W-1:0] max_tx_timer,
  input  logic               phy_busy,
  input  logic               phy_ack,
  output logic               phy_tx_req,
  output logic [2:0]         phy_tx_type,
  output logic               alert_tx_success,
  output logic               alert_tx_failed,
  output logic               alert_tx_discarded,
  output logic               busy
);

  tx_state_e          state_q, state_d;
  logic [2:0]         type_q, type_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               res_ok_q, res_ok_d;
  logic               req_q, req_d;
  logic [2:0]         txt_q, txt_d;
  logic               succ_q, succ_d;
  logic               fail_q, fail_d;
  logic               disc_q, disc_d;
  logic               busy_q, busy_d;

  logic tmr_load, tmr_dec, tmr_expired;
  logic wr_reset, wr_msg, preempt;

  tcpc_tx_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_ni     (reset_L),
    .load_i     (tmr_load),
    .load_val_i (max_tx_timer),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_expired)
  );

  assign wr_reset = transmit_wr && is_reset_type(transmit_type);
  assign wr_msg   = transmit_wr && is_msg_type(transmit_type);
  assign preempt  = wr_reset && !is_reset_type(type_q) &&
                    ((state_q == ST_WAIT_BUS) || (state_q == ST_REQUEST));
  assign tmr_dec  = (state_q == ST_REQUEST);

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    retry_d  = retry_q;
    res_ok_d = res_ok_q;
    succ_d   = 1'b0;
    fail_d   = 1'b0;
    disc_d   = 1'b0;
    tmr_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_reset) begin
          type_d   = transmit_type;
          tmr_load = 1'b1;
          state_d  = ST_REQUEST;
        end else if (wr_msg) begin
          type_d  = transmit_type;
          retry_d = transmit_retry;
          state_d = ST_WAIT_BUS;
        end else if (transmit_wr) begin
          disc_d = 1'b1;
        end
      end

      ST_WAIT_BUS, ST_REQUEST: begin
        disc_d = transmit_wr;
        if (preempt) begin
          type_d   = transmit_type;
          tmr_load = 1'b1;
          state_d  = ST_REQUEST;
        end else if (state_q == ST_WAIT_BUS) begin
          if (!phy_busy) begin
            tmr_load = 1'b1;
            state_d  = ST_REQUEST;
          end
        end else if (phy_ack) begin
          res_ok_d = 1'b1;
          state_d  = ST_REPORT;
        end else if (tmr_expired) begin
          if (is_msg_type(type_q) && (retry_q != '0)) begin
            retry_d = retry_q - 1'b1;
            state_d = ST_WAIT_BUS;
          end else begin
            res_ok_d = 1'b0;
            state_d  = ST_REPORT;
          end
        end
      end

      // First REPORT cycle raises the alert; the alert cycle itself still
      // counts as busy, so IDLE is reached one cycle after the pulse.
      ST_REPORT: begin
        disc_d = transmit_wr;
        if (!succ_q && !fail_q) begin
          succ_d = res_ok_q;
          fail_d = !res_ok_q;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_d  = (state_d == ST_REQUEST);
    txt_d  = req_d ? type_d : '0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      retry_q  <= '0;
      res_ok_q <= 1'b0;
      req_q    <= 1'b0;
      txt_q    <= '0;
      succ_q   <= 1'b0;
      fail_q   <= 1'b0;
      disc_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      retry_q  <= retry_d;
      res_ok_q <= res_ok_d;
      req_q    <= req_d;
      txt_q    <= txt_d;
      succ_q   <= succ_d;
      fail_q   <= fail_d;
      disc_q   <= disc_d;
      busy_q   <= busy_d;
    end
  end

  assign phy_tx_req         = req_q;
  assign phy_tx_type        = txt_q;
  assign alert_tx_success   = succ_q;
  assign alert_tx_failed    = fail_q;
  assign alert_tx_discarded = disc_q;
  assign busy               = busy_q;

endmodule
